// File: rtl/glitcbus_reg_bridge.sv
// glitcbus_reg_bridge
// Register-access bridge that sits in the clk_i domain directly after the
// GLITC bus slave. It synchronises the slave's held wr/rd request levels,
// sends one single-cycle strobe to register bank A or bank B, and returns
// the read data to the slave with a 4-phase acknowledge. A timeout stops a
// dead bank from hanging the bus.
//
// Ports
//   clk_i, rst_n_i            clock (rising edge), synchronous active-low reset
//   gb_addr_i/gb_dat_i        slave address / write data (held with request)
//   gb_selA_i/gb_selB_i       bank selects
//   gb_wr_i/gb_rd_i           request levels (asynchronous to clk_i)
//   gb_dat_o/gb_ack_o         read data and 4-phase acknowledge to the slave
//   {a,b}_addr_o/_dat_o       bank address / write data, stable ISSUE..IDLE
//   {a,b}_wr_o/_rd_o          one-cycle bank strobes
//   {a,b}_dat_i/_ack_i        bank read data and completion
//   err_o/err_cnt_o           error pulse and saturating error count
module glitcbus_reg_bridge #(
    parameter int         SYNC_STAGES = 2,
    parameter int         TO_BITS     = 8,
    parameter int         TIMEOUT     = 200,
    parameter logic [7:0] ERR_DATA    = 8'hEE
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [13:0] gb_addr_i,
    input  logic [7:0]  gb_dat_i,
    input  logic        gb_selA_i,
    input  logic        gb_selB_i,
    input  logic        gb_wr_i,
    input  logic        gb_rd_i,
    output logic [7:0]  gb_dat_o,
    output logic        gb_ack_o,
    output logic [13:0] a_addr_o,
    output logic [7:0]  a_dat_o,
    output logic        a_wr_o,
    output logic        a_rd_o,
    input  logic [7:0]  a_dat_i,
    input  logic        a_ack_i,
    output logic [13:0] b_addr_o,
    output logic [7:0]  b_dat_o,
    output logic        b_wr_o,
    output logic        b_rd_o,
    input  logic [7:0]  b_dat_i,
    input  logic        b_ack_i,
    output logic        err_o,
    output logic [7:0]  err_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // The counter clears in ISSUE and the abort fires on the WAIT edge where it
    // would step to TIMEOUT, i.e. TIMEOUT+1 edges after the strobe.
    localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT - 1);
    localparam logic [TO_BITS-1:0] TO_ZERO = {TO_BITS{1'b0}};
    localparam logic [TO_BITS-1:0] TO_ONE  = {{(TO_BITS-1){1'b0}}, 1'b1};

    state_t                  state_r, state_nxt_s;
    logic [SYNC_STAGES-1:0]  wr_sync_r, rd_sync_r;
    logic                    wr_s, rd_s;
    logic [TO_BITS-1:0]      cnt_r, cnt_nxt_s;
    logic                    sel_b_r, sel_b_nxt_s;
    logic                    dir_rd_r, dir_rd_nxt_s;
    logic [7:0]              gb_dat_r, gb_dat_nxt_s;
    logic                    gb_ack_r, gb_ack_nxt_s;
    logic [13:0]             a_addr_r, a_addr_nxt_s, b_addr_r, b_addr_nxt_s;
    logic [7:0]              a_dat_r, a_dat_nxt_s, b_dat_r, b_dat_nxt_s;
    logic                    a_wr_r, a_wr_nxt_s, a_rd_r, a_rd_nxt_s;
    logic                    b_wr_r, b_wr_nxt_s, b_rd_r, b_rd_nxt_s;
    logic                    err_r, err_nxt_s;
    logic [7:0]              err_cnt_r, err_cnt_nxt_s;
    logic                    bank_ack_s;
    logic [7:0]              bank_dat_s;

    assign wr_s = wr_sync_r[SYNC_STAGES-1];
    assign rd_s = rd_sync_r[SYNC_STAGES-1];

    // Only the bank captured at request time may complete the transfer.
    assign bank_ack_s = sel_b_r ? b_ack_i : a_ack_i;
    assign bank_dat_s = sel_b_r ? b_dat_i : a_dat_i;

    // Request-level synchronisers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_sync_r <= {SYNC_STAGES{1'b0}};
            rd_sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            wr_sync_r <= {wr_sync_r[SYNC_STAGES-2:0], gb_wr_i};
            rd_sync_r <= {rd_sync_r[SYNC_STAGES-2:0], gb_rd_i};
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        sel_b_nxt_s  = sel_b_r;
        dir_rd_nxt_s = dir_rd_r;
        gb_dat_nxt_s = gb_dat_r;
        gb_ack_nxt_s = gb_ack_r;
        a_addr_nxt_s = a_addr_r;
        a_dat_nxt_s  = a_dat_r;
        b_addr_nxt_s = b_addr_r;
        b_dat_nxt_s  = b_dat_r;
        a_wr_nxt_s   = 1'b0;
        a_rd_nxt_s   = 1'b0;
        b_wr_nxt_s   = 1'b0;
        b_rd_nxt_s   = 1'b0;
        err_nxt_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (wr_s | rd_s) begin
                    sel_b_nxt_s  = gb_selB_i;
                    dir_rd_nxt_s = rd_s;
                    if ((wr_s ^ rd_s) && (gb_selA_i ^ gb_selB_i)) begin
                        state_nxt_s = ST_ISSUE;
                        if (gb_selB_i) begin
                            b_addr_nxt_s = gb_addr_i;
                            b_dat_nxt_s  = gb_dat_i;
                            b_wr_nxt_s   = wr_s;
                            b_rd_nxt_s   = rd_s;
                        end else begin
                            a_addr_nxt_s = gb_addr_i;
                            a_dat_nxt_s  = gb_dat_i;
                            a_wr_nxt_s   = wr_s;
                            a_rd_nxt_s   = rd_s;
                        end
                    end else begin
                        // Ambiguous request: answer it with error data, touch no bank.
                        state_nxt_s  = ST_HOLD;
                        gb_ack_nxt_s = 1'b1;
                        gb_dat_nxt_s = ERR_DATA;
                        err_nxt_s    = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_nxt_s = TO_ZERO;
                if (bank_ack_s) begin
                    state_nxt_s  = ST_HOLD;
                    gb_ack_nxt_s = 1'b1;
                    gb_dat_nxt_s = dir_rd_r ? bank_dat_s : 8'h00;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bank_ack_s) begin
                    state_nxt_s  = ST_HOLD;
                    gb_ack_nxt_s = 1'b1;
                    gb_dat_nxt_s = dir_rd_r ? bank_dat_s : 8'h00;
                end else if (cnt_r == TO_LAST) begin
                    state_nxt_s  = ST_HOLD;
                    gb_ack_nxt_s = 1'b1;
                    gb_dat_nxt_s = ERR_DATA;
                    err_nxt_s    = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + TO_ONE;
                end
            end
            ST_HOLD: begin
                if (!wr_s && !rd_s) begin
                    state_nxt_s  = ST_IDLE;
                    gb_ack_nxt_s = 1'b0;
                    gb_dat_nxt_s = 8'h00;
                    a_addr_nxt_s = 14'h0000;
                    a_dat_nxt_s  = 8'h00;
                    b_addr_nxt_s = 14'h0000;
                    b_dat_nxt_s  = 8'h00;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        err_cnt_nxt_s = (err_nxt_s && (err_cnt_r != 8'hFF)) ? (err_cnt_r + 8'h01) : err_cnt_r;
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_r   <= ST_IDLE;
            cnt_r     <= TO_ZERO;
            sel_b_r   <= 1'b0;
            dir_rd_r  <= 1'b0;
            gb_dat_r  <= 8'h00;
            gb_ack_r  <= 1'b0;
            a_addr_r  <= 14'h0000;
            a_dat_r   <= 8'h00;
            b_addr_r  <= 14'h0000;
            b_dat_r   <= 8'h00;
            a_wr_r    <= 1'b0;
            a_rd_r    <= 1'b0;
            b_wr_r    <= 1'b0;
            b_rd_r    <= 1'b0;
            err_r     <= 1'b0;
            err_cnt_r <= 8'h00;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            sel_b_r   <= sel_b_nxt_s;
            dir_rd_r  <= dir_rd_nxt_s;
            gb_dat_r  <= gb_dat_nxt_s;
            gb_ack_r  <= gb_ack_nxt_s;
            a_addr_r  <= a_addr_nxt_s;
            a_dat_r   <= a_dat_nxt_s;
            b_addr_r  <= b_addr_nxt_s;
            b_dat_r   <= b_dat_nxt_s;
            a_wr_r    <= a_wr_nxt_s;
            a_rd_r    <= a_rd_nxt_s;
            b_wr_r    <= b_wr_nxt_s;
            b_rd_r    <= b_rd_nxt_s;
            err_r     <= err_nxt_s;
            err_cnt_r <= err_cnt_nxt_s;
        end
    end

    assign gb_dat_o  = gb_dat_r;
    assign gb_ack_o  = gb_ack_r;
    assign a_addr_o  = a_addr_r;
    assign a_dat_o   = a_dat_r;
    assign a_wr_o    = a_wr_r;
    assign a_rd_o    = a_rd_r;
    assign b_addr_o  = b_addr_r;
    assign b_dat_o   = b_dat_r;
    assign b_wr_o    = b_wr_r;
    assign b_rd_o    = b_rd_r;
    assign err_o     = err_r;
    assign err_cnt_o = err_cnt_r;

endmodule

// File: tb/tb_glitcbus_reg_bridge.sv
// Testbench for glitcbus_reg_bridge: table of transactions with a scoreboard
// of expected read data, plus hand-written reset-in-WAIT and error-counter
// saturation sequences.
module tb_glitcbus_reg_bridge;

    localparam int SYNC = 2;
    localparam int TMO  = 200;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic [13:0] gb_addr_i;
    logic [7:0]  gb_dat_i;
    logic        gb_selA_i, gb_selB_i, gb_wr_i, gb_rd_i;
    logic [7:0]  gb_dat_o;
    logic        gb_ack_o;
    logic [13:0] a_addr_o, b_addr_o;
    logic [7:0]  a_dat_o, b_dat_o, a_dat_i, b_dat_i;
    logic        a_wr_o, a_rd_o, b_wr_o, b_rd_o, a_ack_i, b_ack_i;
    logic        err_o;
    logic [7:0]  err_cnt_o;

    glitcbus_reg_bridge #(.SYNC_STAGES(SYNC), .TO_BITS(8), .TIMEOUT(TMO), .ERR_DATA(8'hEE)) dut (
        .clk_i(clk), .rst_n_i(rst_n_i),
        .gb_addr_i(gb_addr_i), .gb_dat_i(gb_dat_i),
        .gb_selA_i(gb_selA_i), .gb_selB_i(gb_selB_i),
        .gb_wr_i(gb_wr_i), .gb_rd_i(gb_rd_i),
        .gb_dat_o(gb_dat_o), .gb_ack_o(gb_ack_o),
        .a_addr_o(a_addr_o), .a_dat_o(a_dat_o), .a_wr_o(a_wr_o), .a_rd_o(a_rd_o),
        .a_dat_i(a_dat_i), .a_ack_i(a_ack_i),
        .b_addr_o(b_addr_o), .b_dat_o(b_dat_o), .b_wr_o(b_wr_o), .b_rd_o(b_rd_o),
        .b_dat_i(b_dat_i), .b_ack_i(b_ack_i),
        .err_o(err_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        rd;
        logic        sa;
        logic        sb;
        logic [13:0] addr;
        logic [7:0]  dat;
        logic [7:0]  bdat;   // data the bank returns
        int          dly;    // bank ack delay after strobe, -1 = never
        int          hold;   // cycles request stays high after ack
        int          xbank;  // expected strobed bank: 0 none, 1 A, 2 B
        logic [7:0]  xdat;   // expected gb_dat_o
        int          xerr;   // expected err_o pulses
    } vec_t;

    vec_t       vecs[9];
    logic [7:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc;
    int cnt_ard, cnt_awr, cnt_brd, cnt_bwr, cnt_err;
    int err_model = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (a_rd_o) cnt_ard++;
        if (a_wr_o) cnt_awr++;
        if (b_rd_o) cnt_brd++;
        if (b_wr_o) cnt_bwr++;
        if (err_o)  cnt_err++;
    endtask

    task automatic bank_ack(input logic to_b, input logic [7:0] d);
        if (to_b) begin
            b_ack_i = 1'b1; b_dat_i = d;
        end else begin
            a_ack_i = 1'b1; a_dat_i = d;
        end
    endtask

    task automatic run_txn(input vec_t v);
        int strobe_cyc = -1;
        int ack_cyc    = -1;
        int exp_lat;
        int n;
        logic seen;
        logic [7:0] exp_d;
        cnt_ard = 0; cnt_awr = 0; cnt_brd = 0; cnt_bwr = 0; cnt_err = 0;
        exp_q.push_back(v.xdat);
        gb_addr_i = v.addr; gb_dat_i = v.dat;
        gb_selA_i = v.sa;   gb_selB_i = v.sb;
        gb_wr_i = v.wr;     gb_rd_i = v.rd;
        cyc = 0;
        for (int i = 0; i < 400 && ack_cyc < 0; i++) begin
            tick();
            a_ack_i = 1'b0; b_ack_i = 1'b0;
            if (gb_ack_o) begin
                ack_cyc = cyc;
            end else begin
                if (strobe_cyc < 0 && (a_rd_o | a_wr_o | b_rd_o | b_wr_o)) begin
                    strobe_cyc = cyc;
                    check("strobe_lat", strobe_cyc, SYNC + 1);
                    if (a_rd_o | a_wr_o) begin
                        check("a_addr", a_addr_o, v.addr);
                        check("b_idle", {b_addr_o, b_dat_o}, 22'h0);
                        if (a_wr_o) check("a_dat", a_dat_o, v.dat);
                    end else begin
                        check("b_addr", b_addr_o, v.addr);
                        check("a_idle", {a_addr_o, a_dat_o}, 22'h0);
                        if (b_wr_o) check("b_dat", b_dat_o, v.dat);
                    end
                end
                if (strobe_cyc >= 0 && v.dly >= 0 && cyc == strobe_cyc + v.dly)
                    bank_ack(v.sb, v.bdat);
            end
        end
        exp_d = exp_q.pop_front();
        if (ack_cyc < 0) begin
            check("ack_seen", gb_ack_o, 1'b1);
        end else begin
            check("rdata", gb_dat_o, exp_d);
            if (v.xbank == 0)   exp_lat = SYNC + 1;
            else if (v.dly < 0) exp_lat = SYNC + 1 + TMO + 1;
            else                exp_lat = SYNC + 1 + v.dly + 1;
            check("ack_lat", ack_cyc, exp_lat);
        end
        // Bank ack during HOLD must not disturb the returned data.
        for (int i = 0; i < v.hold; i++) begin
            if (i == 0) bank_ack(v.sb, 8'h77);
            tick();
            a_ack_i = 1'b0; b_ack_i = 1'b0;
        end
        check("hold", {gb_ack_o, gb_dat_o}, {1'b1, v.xdat});
        gb_wr_i = 1'b0; gb_rd_i = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n++;
            if (!gb_ack_o) break;
        end
        check("ack_drop", n, SYNC + 1);
        // Bank ack in IDLE is ignored.
        bank_ack(v.sb, 8'h77);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            a_ack_i = 1'b0; b_ack_i = 1'b0;
            seen |= gb_ack_o;
        end
        check("late_ack", seen, 1'b0);
        check("strobes", {4'(cnt_ard), 4'(cnt_awr), 4'(cnt_brd), 4'(cnt_bwr)},
              {4'((v.xbank == 1 && v.rd) ? 1 : 0), 4'((v.xbank == 1 && v.wr) ? 1 : 0),
               4'((v.xbank == 2 && v.rd) ? 1 : 0), 4'((v.xbank == 2 && v.wr) ? 1 : 0)});
        check("err_pulses", cnt_err, v.xerr);
        err_model = (err_model + v.xerr > 255) ? 255 : err_model + v.xerr;
        check("err_cnt", err_cnt_o, err_model);
    endtask

    initial begin
        logic seen;
        vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 14'h0123, 8'h00, 8'h5A,  2,  2, 1, 8'h5A, 0}; // read A
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 14'h3FFF, 8'hC3, 8'h00,  0,  2, 2, 8'h00, 0}; // write B, same-cycle ack
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 14'h0001, 8'h00, 8'h3C,  5,  2, 2, 8'h3C, 0}; // read B
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 14'h2AAA, 8'h96, 8'h00,  1,  2, 1, 8'h00, 0}; // write A
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 14'h0042, 8'h00, 8'h00, -1,  2, 1, 8'hEE, 1}; // timeout
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 14'h0010, 8'h11, 8'h00,  0,  2, 0, 8'hEE, 1}; // wr and rd together
        vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 14'h0020, 8'h00, 8'h00,  0,  2, 0, 8'hEE, 1}; // both selects
        vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 14'h0030, 8'h00, 8'h00,  0,  2, 0, 8'hEE, 1}; // no select
        vecs[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 14'h0000, 8'h00, 8'hFF,  0, 20, 1, 8'hFF, 0}; // hold-off

        rst_n_i = 1'b0;
        gb_addr_i = 14'h0; gb_dat_i = 8'h00; gb_selA_i = 1'b0; gb_selB_i = 1'b0;
        gb_wr_i = 1'b0; gb_rd_i = 1'b0;
        a_dat_i = 8'h00; b_dat_i = 8'h00; a_ack_i = 1'b0; b_ack_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", {gb_ack_o, gb_dat_o, err_o, err_cnt_o, a_wr_o, a_rd_o, b_wr_o, b_rd_o,
                              a_addr_o, a_dat_o, b_addr_o, b_dat_o}, 64'h0);
        rst_n_i = 1'b1;

        for (int k = 0; k < 9; k++) run_txn(vecs[k]);

        // Reset while waiting on bank A.
        gb_addr_i = 14'h0055; gb_selA_i = 1'b1; gb_selB_i = 1'b0; gb_rd_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (a_rd_o) break;
        end
        check("rst_strobe", a_rd_o, 1'b1);
        tick();
        rst_n_i = 1'b0; gb_rd_i = 1'b0;
        tick();
        check("rst_outputs", {gb_ack_o, gb_dat_o, err_o, err_cnt_o, a_wr_o, a_rd_o, b_wr_o, b_rd_o,
                              a_addr_o, a_dat_o, b_addr_o, b_dat_o}, 64'h0);
        rst_n_i = 1'b1;
        bank_ack(1'b0, 8'h99);
        tick();
        a_ack_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen |= gb_ack_o;
        end
        check("rst_late_ack", seen, 1'b0);
        err_model = 0;
        run_txn(vecs[0]);

        // Drive the error counter into saturation.
        for (int k = 0; k < 256; k++) run_txn(vecs[5]);
        check("err_sat", err_cnt_o, 8'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
